// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 PRGA decrypt stage:
// FSM state encoding, default message geometry and the legal plaintext alphabet.
package rc4_pkg;

    localparam int MSG_LEN_DEF = 32;
    localparam int ADDR_W_DEF  = 5;

    // Plaintext is limited to space and lowercase letters
    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_LO    = 8'h61;
    localparam logic [7:0] CHAR_HI    = 8'h7A;

    typedef enum logic [3:0] {
        IDLE,
        RD_I,
        WT_I,
        LD_I,
        RD_J,
        WT_J,
        LD_J,
        WR_I,
        WR_J,
        RD_F,
        WT_F,
        LD_F,
        WR_D,
        DONE
    } prga_state_e;

endpackage

// File: rtl/char_check.sv
// Combinational legality test of one decrypted byte (space or 'a'..'z').
module char_check
    import rc4_pkg::*;
(
    input  logic [7:0] ch,
    output logic       legal
);

    assign legal = (ch == CHAR_SPACE) || ((ch >= CHAR_LO) && (ch <= CHAR_HI));

endmodule

// File: rtl/prga_decrypt.sv
// RC4 keystream generator and decryptor: walks the shuffled S memory, XORs the
// keystream with the ROM ciphertext and stores plaintext, aborting on an illegal byte.
module prga_decrypt
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = MSG_LEN_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic [7:0]        s_address,
    output logic [7:0]        s_data,
    input  logic [7:0]        s_q,
    output logic              s_wren,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [7:0]        rom_q,
    output logic [ADDR_W-1:0] dec_address,
    output logic [7:0]        dec_data,
    output logic              dec_wren,
    output logic              busy,
    output logic              done,
    output logic              key_valid
);

    prga_state_e state, next_state;

    logic [7:0]        i, j, si, sj, f, enc;
    logic [ADDR_W-1:0] k;
    logic              all_legal;
    logic              done_q;
    logic [7:0]        dec_byte;
    logic              byte_legal;
    logic              last_byte;
    logic              idle_like;

    assign dec_byte  = f ^ enc;
    assign last_byte = (k == ADDR_W'(MSG_LEN - 1));
    assign idle_like = (state == IDLE) || (state == DONE);

    char_check u_char_check (
        .ch    (dec_byte),
        .legal (byte_legal)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // done is registered so it rises one cycle after DONE is entered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i         <= '0;
            j         <= '0;
            k         <= '0;
            si        <= '0;
            sj        <= '0;
            f         <= '0;
            enc       <= '0;
            all_legal <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            if (idle_like && start) begin
                i         <= 8'd1;
                j         <= 8'd0;
                k         <= '0;
                all_legal <= 1'b1;
                done_q    <= 1'b0;
            end else if (state == DONE) begin
                done_q <= 1'b1;
            end

            unique case (state)
                LD_I: begin
                    si <= s_q;
                    j  <= j + s_q;
                end
                LD_J: sj <= s_q;
                LD_F: begin
                    f   <= s_q;
                    enc <= rom_q;
                end
                WR_D: begin
                    if (!byte_legal) begin
                        all_legal <= 1'b0;
                    end else if (!last_byte) begin
                        k <= k + 1'b1;
                        i <= i + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Addresses are held through the wait state so registered memories see them
    always_comb begin
        next_state  = state;
        s_address   = '0;
        s_data      = '0;
        s_wren      = 1'b0;
        rom_address = '0;
        dec_address = '0;
        dec_data    = '0;
        dec_wren    = 1'b0;

        unique case (state)
            IDLE, DONE: if (start) next_state = RD_I;
            RD_I: begin
                s_address  = i;
                next_state = WT_I;
            end
            WT_I: begin
                s_address  = i;
                next_state = LD_I;
            end
            LD_I: next_state = RD_J;
            RD_J: begin
                s_address  = j;
                next_state = WT_J;
            end
            WT_J: begin
                s_address  = j;
                next_state = LD_J;
            end
            LD_J: next_state = WR_I;
            WR_I: begin
                s_address  = i;
                s_data     = sj;
                s_wren     = 1'b1;
                next_state = WR_J;
            end
            WR_J: begin
                s_address  = j;
                s_data     = si;
                s_wren     = 1'b1;
                next_state = RD_F;
            end
            RD_F: begin
                s_address   = si + sj;
                rom_address = k;
                next_state  = WT_F;
            end
            WT_F: begin
                s_address   = si + sj;
                rom_address = k;
                next_state  = LD_F;
            end
            LD_F: next_state = WR_D;
            WR_D: begin
                dec_address = k;
                dec_data    = dec_byte;
                dec_wren    = 1'b1;
                next_state  = (!byte_legal || last_byte) ? DONE : RD_I;
            end
            default: next_state = IDLE;
        endcase
    end

    assign busy      = !idle_like;
    assign done      = done_q;
    assign key_valid = done_q & all_legal;

endmodule

// File: doc/prga_decrypt.md
PRGA_DECRYPT -- requirements
Module: prga_decrypt

Interface
REQ-001 The block SHALL have parameter MSG_LEN, default 32, giving the number of ciphertext bytes per message.
REQ-002 The block SHALL have parameter ADDR_W, default 5, giving the width of the ROM and result-RAM address ports (2**ADDR_W >= MSG_LEN).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: one-cycle request to decrypt, driven by the shuffle stage's finish.
REQ-006 The block SHALL have ports s_address, s_data, s_q (output, output, input; 8 bits each) and s_wren (output, 1 bit): the S-memory port, which the memory handler routes to s_memory.
REQ-007 The block SHALL have ports rom_address (output, ADDR_W) and rom_q (input, 8 bits): the encrypted-message ROM port.
REQ-008 The block SHALL have ports dec_address (output, ADDR_W), dec_data (output, 8 bits) and dec_wren (output, 1 bit): the decrypted-message RAM port.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a decrypt is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: high from completion until the next accepted start.
REQ-011 The block SHALL have port key_valid, output, 1 bit: qualified by done; 1 if every byte decrypted to a legal character.

Function
REQ-012 The FSM SHALL have states IDLE, RD_I, WT_I, LD_I, RD_J, WT_J, LD_J, WR_I, WR_J, RD_F, WT_F, LD_F, WR_D and DONE.
REQ-013 In IDLE or DONE, a sampled start SHALL set i=1, j=0 and k=0, clear done and key_valid, and move to RD_I.
REQ-014 A start asserted in any other state SHALL be ignored.
REQ-015 RD_I SHALL drive s_address=i; WT_I is a wait state; LD_I SHALL capture si=s_q and set j=j+s_q mod 256.
REQ-016 RD_J, WT_J and LD_J SHALL do the same for address j and capture sj.
REQ-017 WR_I SHALL write S[i]=sj (s_wren=1), and WR_J SHALL write S[j]=si.
REQ-018 If i==j, both swap writes SHALL still occur and the value in S SHALL be unchanged.
REQ-019 RD_F SHALL drive s_address=(si+sj) mod 256 and rom_address=k; WT_F is a wait state.
REQ-020 LD_F SHALL capture f=s_q and enc=rom_q.
REQ-021 Read data SHALL be sampled only in LD_* states, two edges after the address is driven, so registered-output memories work.
REQ-022 WR_D SHALL drive dec_address=k, dec_data=f^enc and dec_wren=1 for exactly one cycle.
REQ-023 A byte SHALL be legal if it equals 0x20 or lies in 0x61..0x7A.
REQ-024 After WR_D, the FSM SHALL go to DONE if the byte is illegal (key_valid=0) or k==MSG_LEN-1 (key_valid=1 if all bytes were legal).
REQ-025 Otherwise WR_D SHALL set k=k+1 and i=i+1 mod 256 and return to RD_I.
REQ-026 i and j SHALL wrap modulo 256; k SHALL never exceed MSG_LEN-1.
REQ-027 Each byte SHALL take 12 cycles; done SHALL rise 12*MSG_LEN+1 cycles after the start-sampling edge for a full message.
REQ-028 s_wren and dec_wren SHALL be 0 in all states except WR_I/WR_J and WR_D respectively.
REQ-029 busy SHALL be 1 in all states except IDLE and DONE.

Reset
REQ-030 Asserting reset_n low SHALL force IDLE immediately, including mid-operation, and clear i, j, k, si, sj, f and enc.
REQ-031 During reset, all outputs SHALL be 0: s_address, s_data, s_wren, rom_address, dec_address, dec_data, dec_wren, busy, done and key_valid.
REQ-032 Partially written result RAM SHALL NOT be cleared by reset.

Structure
REQ-033 A shared package rc4_pkg SHALL hold the state enum type, the MSG_LEN/ADDR_W defaults and the legal-character constants (0x20, 0x61, 0x7A).
REQ-034 One sub-module, char_check (combinational legality test of one byte), SHALL be instantiated.

Verification
REQ-035 S preloaded as identity, enc[0]=0x63, pulse start: first S writes are S[1]=1 and S[1]=1; first dec write is addr 0, data 0x61.
REQ-036 Same setup, enc[1]=0x64: S[2]=3 and S[3]=2 are written; dec write is addr 1, data 0x61 (keystream 0x05).
REQ-037 Identity S, enc[0]=0x02: exactly one dec write (addr 0, data 0x00); done=1 and key_valid=0 at cycle 13; busy=0.
REQ-038 Full 32-byte message encrypted with a known 24-bit key after KSA: done at cycle 385, key_valid=1, all 32 dec bytes match the reference plaintext.
REQ-039 reset_n pulsed low in WR_J: outputs go to 0 asynchronously, state is IDLE; a subsequent start decrypts normally from k=0.
REQ-040 start pulsed while busy: ignored, k sequence uninterrupted; start pulsed in DONE: done drops next cycle and a new run begins.
